shift_unit_arbiter: RTL and testbench

//  Shares one 32-bit barrel shifter between NUM_REQ requesters, e.g. the ALU

---
 rtl/shift_unit_arbiter_pkg.sv | 17 +
 rtl/shift_unit_arbiter_shift_core.sv | 41 ++++
 rtl/shift_unit_arbiter.sv | 95 +++++++++
 tb/tb_shift_unit_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_unit_arbiter_pkg.sv
// Shared constants and types for the shared barrel-shifter arbiter.
package shift_pkg;
    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_ROTL = 2'b11
    } shift_op_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_e;
endpackage

// File: rtl/shift_unit_arbiter_shift_core.sv
// Combinational 32-bit shifter: five log-stages followed by the out-of-range override.
module shift_core
    import shift_pkg::*;
(
    input  shift_op_e           i_op,
    input  logic [DATA_W-1:0]   i_a,
    input  logic [DATA_W-1:0]   i_b,
    output logic [DATA_W-1:0]   o_res
);
    logic [SHAMT_W-1:0] w_sh;
    logic               w_big;
    logic [DATA_W-1:0]  w_stage;
    logic [DATA_W-1:0]  w_res;

    always_comb begin
        w_sh    = i_b[SHAMT_W-1:0];
        w_big   = |i_b[DATA_W-1:SHAMT_W];
        w_stage = i_a;
        for (int k = 0; k < SHAMT_W; k++) begin
            if (w_sh[k]) begin
                case (i_op)
                    OP_SLL:  w_stage = w_stage << (1 << k);
                    OP_SRL:  w_stage = w_stage >> (1 << k);
                    OP_SRA:  w_stage = DATA_W'($signed(w_stage) >>> (1 << k));
                    default: w_stage = (w_stage << (1 << k)) | (w_stage >> (DATA_W - (1 << k)));
                endcase
            end
        end
        // Amounts of 32 or more saturate; rotation only looks at the low bits.
        w_res = w_stage;
        if (w_big) begin
            case (i_op)
                OP_SLL, OP_SRL: w_res = '0;
                OP_SRA:         w_res = {DATA_W{i_a[DATA_W-1]}};
                default:        w_res = w_stage;
            endcase
        end
    end

    assign o_res = w_res;
endmodule

// File: rtl/shift_unit_arbiter.sv
// Round-robin arbiter sharing one shifter among NUM_REQ requesters, with a single-entry result register.
module shift_unit_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [2*NUM_REQ-1:0]        req_op,
    input  logic [DATA_W*NUM_REQ-1:0]   req_a,
    input  logic [DATA_W*NUM_REQ-1:0]   req_b,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [ID_W-1:0]             rsp_id,
    output logic [DATA_W-1:0]           rsp_data
);
    import shift_pkg::*;

    rsp_state_e         r_state;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_rsp_id;
    logic [DATA_W-1:0]  r_rsp_data;

    logic               w_can_accept;
    logic               w_found;
    logic               w_accept;
    logic [ID_W-1:0]    w_gnt_id;
    logic [NUM_REQ-1:0] w_ready;
    shift_op_e          w_op;
    logic [DATA_W-1:0]  w_a;
    logic [DATA_W-1:0]  w_b;
    logic [DATA_W-1:0]  w_res;

    assign w_can_accept = (r_state == ST_EMPTY) || rsp_ready;

    // Scan from the round-robin pointer; outer loop is the priority order.
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_found && (i == (int'(r_rr_ptr) + j) % NUM_REQ) && req_valid[i]) begin
                    w_found  = 1'b1;
                    w_gnt_id = ID_W'(i);
                end
            end
        end
        w_accept = w_found && w_can_accept && !rst;
    end

    always_comb begin
        w_ready = '0;
        w_op    = OP_SLL;
        w_a     = '0;
        w_b     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == w_gnt_id) begin
                w_ready[i] = w_accept;
                w_op       = shift_op_e'(req_op[2*i +: 2]);
                w_a        = req_a[DATA_W*i +: DATA_W];
                w_b        = req_b[DATA_W*i +: DATA_W];
            end
        end
    end

    shift_core u_shift_core (
        .i_op  (w_op),
        .i_a   (w_a),
        .i_b   (w_b),
        .o_res (w_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_rr_ptr   <= '0;
            r_rsp_id   <= '0;
            r_rsp_data <= '0;
        end else if (w_accept) begin
            r_state    <= ST_FULL;
            r_rsp_id   <= w_gnt_id;
            r_rsp_data <= w_res;
            r_rr_ptr   <= ID_W'((int'(w_gnt_id) + 1) % NUM_REQ);
        end else if (rsp_ready) begin
            r_state    <= ST_EMPTY;
        end
    end

    assign req_ready = w_ready;
    assign rsp_valid = (r_state == ST_FULL);
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Randomized bench for shift_unit_arbiter against a queue-based scoreboard and spec-level shift model.
module tb_shift_unit_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [2*N-1:0]   req_op;
    logic [DW*N-1:0]  req_a;
    logic [DW*N-1:0]  req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IW-1:0]    rsp_id;
    logic [DW-1:0]    rsp_data;

    shift_unit_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ID_W(IW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    typedef struct { int id; logic [31:0] d; } exp_t;

    logic [N-1:0] p_vld;
    logic [1:0]   p_op [N];
    logic [31:0]  p_a  [N];
    logic [31:0]  p_b  [N];
    exp_t         m_q[$];
    int           m_ptr;
    int           m_g;
    int           n_acc;
    int           n_vec;
    int           n_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        bit big;
        sh  = int'(b % 32);
        big = (b >= 32);
        case (op)
            2'b00:   return big ? 32'h0 : a << sh;
            2'b01:   return big ? 32'h0 : a >> sh;
            2'b10:   return big ? {32{a[31]}} : 32'($signed(a) >>> sh);
            default: return (sh == 0) ? a : ((a << sh) | (a >> (32 - sh)));
        endcase
    endfunction

    task automatic drive();
        req_valid = p_vld;
        for (int i = 0; i < N; i++) begin
            req_op[2*i +: 2]  = p_op[i];
            req_a[32*i +: 32] = p_a[i];
            req_b[32*i +: 32] = p_b[i];
        end
    endtask

    // Checks outputs at the falling edge and advances the model across the next rising edge.
    task automatic tick();
        bit can;
        logic [N-1:0] exp_rdy;
        drive();
        @(negedge clk);
        chk("rsp_valid", 32'(rsp_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("rsp_id", 32'(rsp_id), 32'(m_q[0].id));
            chk("rsp_data", rsp_data, m_q[0].d);
        end
        can = (m_q.size() == 0) || rsp_ready;
        m_g = -1;
        if (can)
            for (int j = 0; j < N; j++)
                if (m_g < 0 && p_vld[(m_ptr + j) % N]) m_g = (m_ptr + j) % N;
        exp_rdy = '0;
        if (m_g >= 0) exp_rdy[m_g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (m_q.size() != 0 && rsp_ready) void'(m_q.pop_front());
        if (m_g >= 0) begin
            m_q.push_back('{m_g, ref_shift(p_op[m_g], p_a[m_g], p_b[m_g])});
            m_ptr = (m_g + 1) % N;
            n_acc++;
        end
        @(posedge clk);
        #1;
        if (m_g >= 0) p_vld[m_g] = 1'b0;
    endtask

    task automatic new_req(input int i);
        p_vld[i] = 1'b1;
        p_op[i]  = 2'($urandom);
        p_a[i]   = ($urandom_range(7) == 0) ? 32'h8000_0000 : $urandom;
        case ($urandom_range(3))
            0:       p_b[i] = $urandom;
            3:       p_b[i] = 32'd32;
            default: p_b[i] = $urandom_range(31);
        endcase
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        p_vld[i] = 1'b1; p_op[i] = op; p_a[i] = a; p_b[i] = b;
    endtask

    initial begin
        logic [31:0] held_d;
        logic [IW-1:0] held_id;
        int prev_id;
        int target;
        int n_act;
        n_vec = 0; n_err = 0; n_acc = 0; m_ptr = 0; m_g = -1;
        p_vld = '0;
        for (int i = 0; i < N; i++) begin p_op[i] = '0; p_a[i] = '0; p_b[i] = '0; end
        rsp_ready = 1'b1;

        // Reset state, with a live request that must not be granted
        set_req(0, 2'b00, 32'h1, 32'd4);
        drive();
        #3;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_valid", 32'(rsp_valid), 32'h0);
        chk("rst_id", 32'(rsp_id), 32'h0);
        chk("rst_data", rsp_data, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // 1: single SLL on req 0, latency one cycle
        rsp_ready = 1'b0;
        tick();
        chk("t1_valid", 32'(rsp_valid), 32'h1);
        chk("t1_data", rsp_data, 32'h0000_0010);
        chk("t1_id", 32'(rsp_id), 32'h0);
        rsp_ready = 1'b1;
        tick();

        // 2: amount saturation
        set_req(0, 2'b01, 32'h8000_0000, 32'h20); tick();
        chk("t2_srl", rsp_data, 32'h0);
        set_req(0, 2'b10, 32'h8000_0000, 32'h20); tick();
        chk("t2_sra", rsp_data, 32'hFFFF_FFFF);
        set_req(0, 2'b11, 32'h8000_0000, 32'h20); tick();
        chk("t2_rotl", rsp_data, 32'h8000_0000);
        tick();

        // 3: fairness, two requesters always valid
        prev_id = -1;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < 2; i++) if (!p_vld[i]) new_req(i);
            tick();
            chk("t3_busy", 32'(rsp_valid), 32'h1);
            if (prev_id >= 0) chk("t3_alt", 32'(rsp_id), 32'(prev_id ^ 1));
            prev_id = int'(rsp_id);
        end

        // 4: backpressure for 5 cycles, then drain + grant together
        for (int i = 0; i < 2; i++) if (!p_vld[i]) new_req(i);
        rsp_ready = 1'b0;
        held_d  = rsp_data;
        held_id = rsp_id;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t4_data", rsp_data, held_d);
            chk("t4_id", 32'(rsp_id), 32'(held_id));
        end
        rsp_ready = 1'b1;
        tick();
        chk("t4_next", 32'(rsp_valid), 32'h1);
        chk("t4_next_id", 32'(rsp_id), 32'(m_q[0].id));

        // 5: async reset while stalled
        for (int i = 0; i < 2; i++) if (!p_vld[i]) new_req(i);
        rsp_ready = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("t5_valid", 32'(rsp_valid), 32'h0);
        chk("t5_ready", 32'(req_ready), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_q.delete();
        m_ptr = 0;
        for (int i = 0; i < 2; i++) if (!p_vld[i]) new_req(i);
        tick();
        chk("t5_first", 32'(rsp_id), 32'h0);

        // 6: random traffic from 2..4 requesters with random backpressure
        target = n_acc + 2000;
        n_act  = 2;
        for (int cyc = 0; cyc < 20000 && n_acc < target; cyc++) begin
            if (cyc % 250 == 0) n_act = 2 + $urandom_range(2);
            rsp_ready = ($urandom_range(3) != 0);
            for (int i = 0; i < n_act; i++)
                if (!p_vld[i] && $urandom_range(3) != 0) new_req(i);
            tick();
        end
        chk("t6_budget", 32'(n_acc >= target), 32'h1);
        rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        chk("t6_drained", 32'(rsp_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
